dlx_fetch_unit: RTL and testbench
=================================

Name: dlx_fetch_unit

Overview:
- Instruction-fetch stage of the DLX pipeline, directly upstream of the instruction SRAM.
- Drives the SRAM chip-select, output-enable, write-enable and address, and captures the returned instruction word.
- Buffers fetched words in a small prefetch queue and presents them to decode with a valid/stall handshake.
- Accepts branch/jump redirects from later stages and flushes the queue on each one.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- QDEPTH, 2, prefetch queue entries; legal values 2..8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_cs  out  1  SRAM chip select.
- imem_oe  out  1  SRAM output enable.
- imem_we  out  1  SRAM write enable; tied 0.
- imem_addr  out  32  SRAM byte address, word-aligned.
- imem_rdata  in  [0:31]  SRAM read data; combinational, valid in the same cycle as imem_addr.
- stall  in  1  decode cannot accept this cycle.
- redirect_valid  in  1  control-flow change request.
- redirect_pc  in  32  new fetch target; bits [1:0] are ignored.
- halt_req  in  1  stop issuing fetches.
- if_valid  out  1  if_instr and if_pc are valid.
- if_instr  out  [0:31]  instruction word; bit 0 is the opcode MSB.
- if_pc  out  32  address of if_instr.
- if_npc  out  32  if_pc + 4, modulo 2^32.
- halted  out  1  fetch FSM is in HALTED.

Behaviour:
- Reset (asynchronous, while reset_n = 0):
  - FSM = BOOT, fetch_pc = RESET_PC, queue empty.
  - Outputs: imem_cs = 0, imem_oe = 0, imem_we = 0, imem_addr = RESET_PC, if_valid = 0, if_instr = 0, if_pc = 0, if_npc = 0, halted = 0.
- FSM states:
  - BOOT: no fetch; next state FETCH unconditionally. Guarantees one quiet cycle after reset release.
  - FETCH: issues fetches; goes to HALTED when halt_req = 1 and redirect_valid = 0.
  - HALTED: no fetch, halted = 1; goes to FETCH on redirect_valid. The queue still drains to decode.
- Fetch issue:
  - Condition: FSM = FETCH and (queue not full, or a dequeue happens this cycle) and redirect_valid = 0.
  - On issue: imem_cs = imem_oe = 1 and imem_addr = fetch_pc.
  - At the clock edge: {imem_rdata, fetch_pc} is enqueued and fetch_pc <= fetch_pc + 4.
  - No issue: imem_cs = imem_oe = 0; imem_addr holds fetch_pc.
- Dequeue: occurs when if_valid = 1 and stall = 0. if_valid / if_instr / if_pc reflect the queue head combinationally.
- Latency and throughput:
  - An address issued in cycle N is visible on if_valid / if_instr in cycle N+1.
  - Sustained rate is 1 instruction per cycle when stall = 0.
- Full queue: enqueue and dequeue in the same cycle are both allowed; the count is unchanged.
- Empty queue: if_valid = 0; the stall input is ignored.
- Redirect (highest priority):
  - Same cycle: no issue, no dequeue; imem_cs = 0.
  - At the edge: queue flushed (count = 0) and fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - The new target is issued in the next cycle.
  - Redirect in BOOT is honoured (fetch_pc is updated) and BOOT still lasts its one cycle.
- Simultaneous halt_req and redirect_valid: the redirect wins; the FSM goes to FETCH.
- Wrap-around: fetch_pc 32'hFFFF_FFFC + 4 = 32'h0000_0000; if_npc wraps the same way.
- imem_we is always 0. This stage never writes memory.
- Reset asserted mid-operation: all state returns to reset values asynchronously; in-flight queue contents are discarded.

Decomposition:
- Package dlx_fetch_pkg:
  - ADDR_W = 32, INSTR_W = 32, PC_STEP = 4.
  - fetch_state_t enum {BOOT, FETCH, HALTED}.
  - NOP_INSTR = 32'h0000_0000.
- Sub-module dlx_fetch_queue:
  - Parameterised QDEPTH FIFO of {instr, pc}.
  - Ports: push, pop, flush, full, empty, head.
  - flush overrides push and pop.
- Top-level dlx_fetch_unit holds the FSM, fetch_pc and the issue/redirect logic.

Test Plan:
- Reset then release, SRAM model returning 0x2001AAAA @0, 0x8003_0080 @4, 0x2822_0A0A @8 -> cycle 0 after release cs = 0; cycle 1 addr = 0; cycle 2 if_valid = 1, if_instr = 0x2001AAAA, if_pc = 0, if_npc = 4; then 4 and 8 on consecutive cycles.
- stall = 1 held 5 cycles with QDEPTH = 2 -> exactly 2 entries fetched then cs = 0; head held stable; on stall release, words are delivered in order with no gaps or duplicates.
- redirect_valid with redirect_pc = 0x0000_0013 while the queue is full -> same cycle cs = 0 and if_valid ignored; next cycle addr = 0x10; queue flushed; first word out has if_pc = 0x10.
- halt_req pulsed with 2 entries queued -> halted = 1, no further cs, both entries drained; then redirect to 0x0 -> FETCH resumes at 0.
- redirect to 0xFFFF_FFFC, stall = 0 -> addresses FFFF_FFFC then 0000_0000; if_npc = 0 for the first word.
- reset_n asserted mid-stream -> cs = 0 and if_valid = 0 immediately without a clock edge; after release the BOOT cycle repeats and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/dlx_fetch_pkg.sv
// Shared types and constants for the DLX instruction-fetch stage.
package dlx_fetch_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/dlx_fetch_queue.sv
// Prefetch FIFO of {instr, pc}; flush empties it and overrides push/pop.
module dlx_fetch_queue
  import dlx_fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PW = (QDEPTH > 2) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  fetch_entry_t  mem_q [QDEPTH];
  fetch_entry_t  mem_d [QDEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s, do_pop_s;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(QDEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign full  = (count_q == CW'(QDEPTH));
  assign empty = (count_q == CW'(0));
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dlx_fetch_unit.sv
// DLX instruction-fetch stage: drives the instruction SRAM, buffers words
// in a prefetch queue and hands them to decode; redirects flush the queue.
module dlx_fetch_unit
  import dlx_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_cs,
  output logic        imem_oe,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  input  logic [0:31] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        if_valid,
  output logic [0:31] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_npc,
  output logic        halted
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              issue_s, deq_s;
  logic              q_full_s, q_empty_s;
  fetch_entry_t      push_data_s, head_s;

  dlx_fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (issue_s),
    .pop       (deq_s),
    .flush     (redirect_valid),
    .push_data (push_data_s),
    .full      (q_full_s),
    .empty     (q_empty_s),
    .head      (head_s)
  );

  // Issue/dequeue decisions; a redirect suppresses both in its cycle.
  always_comb begin
    deq_s   = !q_empty_s && !stall && !redirect_valid;
    issue_s = (state_q == FETCH) && (!q_full_s || deq_s) && !redirect_valid;
    push_data_s.instr = imem_rdata;
    push_data_s.pc    = fetch_pc_q;
  end

  // FSM next state and fetch address update.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH: begin
        if (halt_req && !redirect_valid) begin
          state_d = HALTED;
        end else begin
          state_d = FETCH;
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          state_d = FETCH;
        end else begin
          state_d = HALTED;
        end
      end
      default: state_d = BOOT;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
    end else if (issue_s) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  // FSM and fetch PC registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= BOOT;
      fetch_pc_q <= word_align(RESET_PC);
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // SRAM strobes and decode-side view of the queue head.
  always_comb begin
    imem_cs   = issue_s;
    imem_oe   = issue_s;
    imem_we   = 1'b0;
    imem_addr = fetch_pc_q;
    if_valid  = !q_empty_s;
    halted    = (state_q == HALTED);
    if (!q_empty_s) begin
      if_instr = head_s.instr;
      if_pc    = head_s.pc;
      if_npc   = head_s.pc + PC_STEP;
    end else begin
      if_instr = NOP_INSTR;
      if_pc    = 32'h0000_0000;
      if_npc   = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_dlx_fetch_unit.sv
// Self-checking bench for dlx_fetch_unit: directed cycle checks plus a
// scoreboard of expected fetch addresses consumed as decode accepts words.
module tb_dlx_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_cs, imem_oe, imem_we;
  logic [31:0] imem_addr;
  logic [0:31] imem_rdata;
  logic        stall, redirect_valid, halt_req;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [0:31] if_instr;
  logic [31:0] if_pc, if_npc;
  logic        halted;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_deliv  = 0;
  int          ncs;
  int          d0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  dlx_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_cs        (imem_cs),
    .imem_oe        (imem_oe),
    .imem_we        (imem_we),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_npc         (if_npc),
    .halted         (halted)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2001_AAAA;
      32'h0000_0004: return 32'h8003_0080;
      32'h0000_0008: return 32'h2822_0A0A;
      default:       return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_restart(input logic [31:0] target);
    sb_q.delete();
    for (int i = 0; i < 32; i++) sb_q.push_back(target + 32'(4 * i));
  endtask

  task automatic monitor();
    logic [31:0] e;
    check_eq("we_tied", 32'(imem_we), 32'd0);
    if (if_valid && !stall && !redirect_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got delivery pc %h expected none", if_pc);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_pc", if_pc, e);
        check_eq("sb_instr", if_instr, mem_word(e));
        check_eq("sb_npc", if_npc, e + 32'd4);
        n_deliv++;
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic fin();
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      half();
      fin();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; halt_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    half();
    check_eq("rst_cs", 32'(imem_cs), 32'd0);
    check_eq("rst_oe", 32'(imem_oe), 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_valid", 32'(if_valid), 32'd0);
    check_eq("rst_instr", if_instr, 32'h0);
    check_eq("rst_pc", if_pc, 32'h0);
    check_eq("rst_npc", if_npc, 32'h0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    fin();

    // Boot and first three fetches
    reset_n = 1'b1; sb_restart(32'h0);
    half(); check_eq("boot_cs", 32'(imem_cs), 32'd0); check_eq("boot_valid", 32'(if_valid), 32'd0); fin();
    half(); check_eq("c1_cs", 32'(imem_cs), 32'd1); check_eq("c1_addr", imem_addr, 32'h0);
    check_eq("c1_valid", 32'(if_valid), 32'd0); fin();
    half(); check_eq("c2_valid", 32'(if_valid), 32'd1); check_eq("c2_instr", if_instr, 32'h2001_AAAA);
    check_eq("c2_pc", if_pc, 32'h0); check_eq("c2_npc", if_npc, 32'h4); fin();
    half(); check_eq("c3_pc", if_pc, 32'h4); check_eq("c3_instr", if_instr, 32'h8003_0080); fin();
    half(); check_eq("c4_pc", if_pc, 32'h8); check_eq("c4_instr", if_instr, 32'h2822_0A0A); fin();

    // Stall from an empty queue: exactly QDEPTH fetches, head held
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100; sb_restart(32'h100);
    half(); check_eq("redir_stall_cs", 32'(imem_cs), 32'd0); fin();
    redirect_valid = 1'b0; ncs = 0;
    repeat (5) begin half(); if (imem_cs) ncs++; fin(); end
    check_eq("stall_fetches", 32'(ncs), 32'd2);
    half(); check_eq("stall_head", if_pc, 32'h100); check_eq("stall_cs", 32'(imem_cs), 32'd0); fin();
    stall = 1'b0; d0 = n_deliv;
    run(4);
    check_eq("stall_release_rate", 32'(n_deliv - d0), 32'd4);

    // Redirect while the queue is full
    stall = 1'b1; run(2);
    half(); check_eq("full_cs", 32'(imem_cs), 32'd0); check_eq("full_valid", 32'(if_valid), 32'd1); fin();
    stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h13; sb_restart(32'h10);
    half(); check_eq("redir_cs", 32'(imem_cs), 32'd0); fin();
    redirect_valid = 1'b0;
    half(); check_eq("redir_addr", imem_addr, 32'h10); check_eq("redir_cs1", 32'(imem_cs), 32'd1);
    check_eq("redir_flushed", 32'(if_valid), 32'd0); fin();
    half(); check_eq("redir_first_pc", if_pc, 32'h10); fin();

    // Halt with two entries queued, drain, then resume at 0
    stall = 1'b1; run(2);
    halt_req = 1'b1; half(); fin();
    halt_req = 1'b0;
    half(); check_eq("halt_halted", 32'(halted), 32'd1); check_eq("halt_cs", 32'(imem_cs), 32'd0); fin();
    stall = 1'b0; d0 = n_deliv; ncs = 0;
    repeat (4) begin half(); if (imem_cs) ncs++; fin(); end
    check_eq("halt_drained", 32'(n_deliv - d0), 32'd2);
    check_eq("halt_no_cs", 32'(ncs), 32'd0);
    half(); check_eq("halt_empty", 32'(if_valid), 32'd0); check_eq("halt_still", 32'(halted), 32'd1); fin();
    redirect_valid = 1'b1; redirect_pc = 32'h0; sb_restart(32'h0);
    half(); check_eq("resume_halted", 32'(halted), 32'd1); fin();
    redirect_valid = 1'b0;
    half(); check_eq("resume_unhalted", 32'(halted), 32'd0); check_eq("resume_cs", 32'(imem_cs), 32'd1);
    check_eq("resume_addr", imem_addr, 32'h0); fin();
    half(); check_eq("resume_pc", if_pc, 32'h0); fin();

    // Address wrap-around
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; sb_restart(32'hFFFF_FFFC);
    half(); fin();
    redirect_valid = 1'b0;
    half(); check_eq("wrap_addr0", imem_addr, 32'hFFFF_FFFC); check_eq("wrap_cs", 32'(imem_cs), 32'd1); fin();
    half(); check_eq("wrap_addr1", imem_addr, 32'h0); check_eq("wrap_pc", if_pc, 32'hFFFF_FFFC);
    check_eq("wrap_npc", if_npc, 32'h0); fin();
    half(); check_eq("wrap_pc1", if_pc, 32'h0); check_eq("wrap_npc1", if_npc, 32'h4); fin();

    // Asynchronous reset mid-stream
    half(); check_eq("pre_reset_valid", 32'(if_valid), 32'd1); fin();
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_cs", 32'(imem_cs), 32'd0);
    check_eq("async_valid", 32'(if_valid), 32'd0);
    check_eq("async_addr", imem_addr, 32'h0);
    check_eq("async_pc", if_pc, 32'h0);
    sb_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1; sb_restart(32'h0);
    half(); check_eq("reboot_cs", 32'(imem_cs), 32'd0); fin();
    half(); check_eq("reboot_cs1", 32'(imem_cs), 32'd1); check_eq("reboot_addr", imem_addr, 32'h0); fin();
    half(); check_eq("reboot_pc", if_pc, 32'h0); fin();

    // Redirect during BOOT
    #2 reset_n = 1'b0;
    #1;
    @(posedge clk); #1;
    reset_n = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h42; sb_restart(32'h40);
    half(); check_eq("bootredir_cs", 32'(imem_cs), 32'd0); fin();
    redirect_valid = 1'b0;
    half(); check_eq("bootredir_cs1", 32'(imem_cs), 32'd1); check_eq("bootredir_addr", imem_addr, 32'h40); fin();
    half(); check_eq("bootredir_pc", if_pc, 32'h40); fin();
    run(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
